// File: rtl/cache_nway.sv
// cache_nway: blocking, write-back, write-allocate set-associative cache.
// It sits between the CPU pipeline and the AXI bridge, and its tag/valid/dirty/data
// state lives in internal register arrays. A miss picks the lowest invalid way as the
// victim; if every way is valid it uses the set's round-robin pointer.
// CACOP maintenance operations and a sticky refill-protocol error flag are included.
module cache_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4,
    localparam int IDX_W     = $clog2(SETS),
    localparam int OFF_W     = $clog2(LINE_WORDS) + 2,
    localparam int TAG_W     = 32 - IDX_W - OFF_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid,
    input  logic                    op,
    input  logic [IDX_W-1:0]        index,
    input  logic [TAG_W-1:0]        tag,
    input  logic [OFF_W-1:0]        offset,
    input  logic [3:0]              wstrb,
    input  logic [31:0]             wdata,
    input  logic                    uncache,
    input  logic                    cacop_en,
    input  logic [1:0]              cacop_code,
    input  logic [31:0]             cacop_pa,
    output logic                    addr_ok,
    output logic                    data_ok,
    output logic [31:0]             rdata,
    output logic                    rd_req,
    output logic [2:0]              rd_type,
    output logic [31:0]             rd_addr,
    input  logic                    rd_rdy,
    input  logic                    ret_valid,
    input  logic                    ret_last,
    input  logic [31:0]             ret_data,
    output logic                    wr_req,
    output logic [2:0]              wr_type,
    output logic [31:0]             wr_addr,
    output logic [3:0]              wr_wstrb,
    output logic [LINE_WORDS*32-1:0] wr_data,
    input  logic                    wr_rdy,
    output logic                    err
);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int BEAT_W = OFF_W - 2;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LOOKUP = 3'd1, S_WB = 3'd2, S_RD = 3'd3,
        S_REFILL = 3'd4, S_DONE = 3'd5, S_CACOP = 3'd6
    } state_e;

    state_e             state_r, state_s;
    logic               req_op_r, req_unc_r, req_cop_r, cop_inv_r, beat_full_r, err_r;
    logic [1:0]         req_code_r;
    logic [IDX_W-1:0]   req_idx_r;
    logic [TAG_W-1:0]   req_tag_r;
    logic [BEAT_W-1:0]  req_word_r, beat_r;
    logic [3:0]         req_wstrb_r;
    logic [31:0]        req_wdata_r, unc_data_r;
    logic [WAY_W-1:0]   cop_way_r, vict_r;

    logic [SETS-1:0]    valid_r [WAYS];
    logic [SETS-1:0]    dirty_r [WAYS];
    logic [WAY_W-1:0]   rr_r    [SETS];
    logic [TAG_W-1:0]   tag_r   [WAYS][SETS];
    logic [31:0]        data_r  [WAYS][SETS][LINE_WORDS];

    logic               hit_s, inv_found_s, unused_s;
    logic [WAY_W-1:0]   hit_way_s, inv_way_s, vict_sel_s;

    assign unused_s = ^{offset[1:0], cacop_pa[OFF_W-1:0]};

    // Byte-lane merge of store data into an existing word
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        end
        return res;
    endfunction

    // Tag compare across all ways and invalid-first / round-robin victim choice
    always_comb begin
        hit_s       = 1'b0;
        hit_way_s   = '0;
        inv_found_s = 1'b0;
        inv_way_s   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_s       = hit_s | (valid_r[w][req_idx_r] & (tag_r[w][req_idx_r] == req_tag_r));
            hit_way_s   = (valid_r[w][req_idx_r] && tag_r[w][req_idx_r] == req_tag_r) ? WAY_W'(w) : hit_way_s;
            inv_found_s = inv_found_s | ~valid_r[w][req_idx_r];
            inv_way_s   = valid_r[w][req_idx_r] ? inv_way_s : WAY_W'(w);
        end
        vict_sel_s = inv_found_s ? inv_way_s : rr_r[req_idx_r];
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (cacop_en)   state_s = S_CACOP;
                else if (valid) state_s = S_LOOKUP;
                else            state_s = S_IDLE;
            end
            S_LOOKUP: begin
                if (req_unc_r)  state_s = req_op_r ? S_WB : S_RD;
                else if (hit_s) state_s = S_DONE;
                else if (valid_r[vict_sel_s][req_idx_r] && dirty_r[vict_sel_s][req_idx_r]) state_s = S_WB;
                else            state_s = S_RD;
            end
            S_WB: begin
                if (wr_rdy) state_s = (req_unc_r || req_cop_r) ? S_DONE : S_RD;
                else        state_s = S_WB;
            end
            S_RD: begin
                if (rd_rdy) state_s = S_REFILL;
                else        state_s = S_RD;
            end
            S_REFILL: begin
                if (ret_valid && ret_last) state_s = S_DONE;
                else                       state_s = S_REFILL;
            end
            S_DONE: state_s = S_IDLE;
            S_CACOP: begin
                case (req_code_r)
                    2'd1: state_s = (valid_r[cop_way_r][req_idx_r] && dirty_r[cop_way_r][req_idx_r]) ? S_WB : S_DONE;
                    2'd2: state_s = (hit_s && dirty_r[hit_way_s][req_idx_r]) ? S_WB : S_DONE;
                    default: state_s = S_DONE;
                endcase
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register, request latch, victim choice, refill beat tracking and error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            req_op_r    <= 1'b0;
            req_unc_r   <= 1'b0;
            req_cop_r   <= 1'b0;
            req_code_r  <= 2'd0;
            req_idx_r   <= '0;
            req_tag_r   <= '0;
            req_word_r  <= '0;
            req_wstrb_r <= 4'd0;
            req_wdata_r <= 32'd0;
            cop_way_r   <= '0;
            cop_inv_r   <= 1'b0;
            vict_r      <= '0;
            beat_r      <= '0;
            beat_full_r <= 1'b0;
            unc_data_r  <= 32'd0;
            err_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                S_IDLE: begin
                    if (cacop_en) begin
                        req_cop_r  <= 1'b1;
                        req_op_r   <= 1'b0;
                        req_unc_r  <= 1'b0;
                        req_code_r <= cacop_code;
                        req_idx_r  <= cacop_pa[IDX_W+OFF_W-1:OFF_W];
                        req_tag_r  <= cacop_pa[31 -: TAG_W];
                        cop_way_r  <= cacop_pa[WAY_W-1:0];
                    end else if (valid) begin
                        req_cop_r   <= 1'b0;
                        req_op_r    <= op;
                        req_unc_r   <= uncache;
                        req_idx_r   <= index;
                        req_tag_r   <= tag;
                        req_word_r  <= offset[OFF_W-1:2];
                        req_wstrb_r <= wstrb;
                        req_wdata_r <= wdata;
                    end
                end
                S_LOOKUP: vict_r <= hit_s ? hit_way_s : vict_sel_s;
                S_CACOP: begin
                    vict_r    <= (req_code_r == 2'd2) ? hit_way_s : cop_way_r;
                    cop_inv_r <= (req_code_r == 2'd0) || (req_code_r == 2'd1) ||
                                 ((req_code_r == 2'd2) && hit_s);
                end
                S_RD: begin
                    beat_r      <= '0;
                    beat_full_r <= 1'b0;
                end
                S_REFILL: begin
                    if (ret_valid) begin
                        if (req_unc_r) begin
                            unc_data_r <= ret_data;
                        end else begin
                            if (beat_full_r || (ret_last && beat_r != LAST_BEAT)) err_r <= 1'b1;
                            if (beat_r == LAST_BEAT && !ret_last) beat_full_r <= 1'b1;
                        end
                        if (beat_r != LAST_BEAT) beat_r <= beat_r + BEAT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Valid/dirty bits and round-robin pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_r[w] <= '0;
                dirty_r[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) rr_r[s] <= '0;
        end else begin
            case (state_r)
                S_REFILL: begin
                    if (ret_valid && ret_last && !req_unc_r) begin
                        valid_r[vict_r][req_idx_r] <= 1'b1;
                        dirty_r[vict_r][req_idx_r] <= req_op_r;
                        rr_r[req_idx_r]            <= rr_r[req_idx_r] + WAY_W'(1);
                    end
                end
                S_DONE: begin
                    if (req_cop_r && cop_inv_r) begin
                        valid_r[vict_r][req_idx_r] <= 1'b0;
                        dirty_r[vict_r][req_idx_r] <= 1'b0;
                    end else if (!req_cop_r && !req_unc_r && req_op_r) begin
                        dirty_r[vict_r][req_idx_r] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays: refill beats, store merge, CACOP tag clear
    always_ff @(posedge clk) begin
        case (state_r)
            S_REFILL: begin
                if (ret_valid && !req_unc_r) begin
                    data_r[vict_r][req_idx_r][beat_r] <= ret_data;
                    if (ret_last) tag_r[vict_r][req_idx_r] <= req_tag_r;
                end
            end
            S_DONE: begin
                if (req_cop_r && cop_inv_r) begin
                    tag_r[vict_r][req_idx_r] <= '0;
                end else if (!req_cop_r && !req_unc_r && req_op_r) begin
                    data_r[vict_r][req_idx_r][req_word_r] <=
                        merge_bytes(data_r[vict_r][req_idx_r][req_word_r], req_wdata_r, req_wstrb_r);
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state and latched request
    always_comb begin
        addr_ok  = (state_r == S_IDLE) && (valid || cacop_en);
        data_ok  = (state_r == S_DONE);
        err      = err_r;
        rd_req   = (state_r == S_RD);
        wr_req   = (state_r == S_WB);
        rd_type  = req_unc_r ? 3'b010 : 3'b100;
        rd_addr  = req_unc_r ? {req_tag_r, req_idx_r, req_word_r, 2'b00}
                             : {req_tag_r, req_idx_r, {OFF_W{1'b0}}};
        wr_data  = '0;
        if (req_unc_r) begin
            wr_type       = 3'b010;
            wr_addr       = {req_tag_r, req_idx_r, req_word_r, 2'b00};
            wr_wstrb      = req_wstrb_r;
            wr_data[31:0] = req_wdata_r;
        end else begin
            wr_type  = 3'b100;
            wr_addr  = {tag_r[vict_r][req_idx_r], req_idx_r, {OFF_W{1'b0}}};
            wr_wstrb = 4'b1111;
            for (int i = 0; i < LINE_WORDS; i++) wr_data[i*32 +: 32] = data_r[vict_r][req_idx_r][i];
        end
        if (state_r == S_DONE && !req_cop_r && !req_op_r) begin
            rdata = req_unc_r ? unc_data_r : data_r[vict_r][req_idx_r][req_word_r];
        end else begin
            rdata = 32'd0;
        end
    end
endmodule

// File: tb/tb_cache_nway.sv
// Directed self-checking bench for cache_nway (WAYS=2, SETS=256, LINE_WORDS=4).
module tb_cache_nway;
    logic         clk = 1'b0, reset = 1'b1;
    logic         valid = 1'b0, op = 1'b0, uncache = 1'b0, cacop_en = 1'b0;
    logic [7:0]   index = '0;
    logic [19:0]  tag = '0;
    logic [3:0]   offset = '0, wstrb = '0;
    logic [31:0]  wdata = '0, cacop_pa = '0, ret_data = '0;
    logic [1:0]   cacop_code = '0;
    logic         rd_rdy = 1'b0, ret_valid = 1'b0, ret_last = 1'b0, wr_rdy = 1'b0;
    logic         addr_ok, data_ok, rd_req, wr_req, err;
    logic [31:0]  rdata, rd_addr, wr_addr;
    logic [2:0]   rd_type, wr_type;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    int           total = 0, bad = 0, rd_cnt = 0, wr_cnt = 0;

    cache_nway #(.WAYS(2), .SETS(256), .LINE_WORDS(4)) dut (
        .clk(clk), .reset(reset), .valid(valid), .op(op), .index(index), .tag(tag), .offset(offset),
        .wstrb(wstrb), .wdata(wdata), .uncache(uncache), .cacop_en(cacop_en), .cacop_code(cacop_code),
        .cacop_pa(cacop_pa), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .rd_req(rd_req),
        .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
        .ret_data(ret_data), .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy), .err(err)
    );

    always #5 clk = ~clk;

    // Count bridge handshakes so "no bridge traffic" can be checked
    always @(posedge clk) begin
        if (rd_req && rd_rdy) rd_cnt <= rd_cnt + 1;
        if (wr_req && wr_rdy) wr_cnt <= wr_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string t, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", t, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                         input logic u);
        valid = 1'b1; op = w; tag = a[31:12]; index = a[11:4]; offset = a[3:0];
        wstrb = s; wdata = d; uncache = u;
        #1;
        chk("addr_ok", addr_ok, 1'b1);
        tick();
        valid = 1'b0; op = 1'b0; uncache = 1'b0;
    endtask

    task automatic wait_done(input string t, input logic [31:0] exp_rd);
        int n;
        n = 0;
        while (data_ok !== 1'b1 && n < 50) begin tick(); n++; end
        chk({t, "_data_ok"}, data_ok, 1'b1);
        chk({t, "_rdata"}, rdata, exp_rd);
        tick();
    endtask

    task automatic serve_rd(input string t, input logic [2:0] et, input logic [31:0] ea,
                            input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                            input logic [31:0] w3, input int nbeats);
        int n;
        logic [31:0] words [4];
        words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
        n = 0;
        while (rd_req !== 1'b1 && n < 50) begin tick(); n++; end
        chk({t, "_rd_req"}, rd_req, 1'b1);
        chk({t, "_rd_type"}, rd_type, et);
        chk({t, "_rd_addr"}, rd_addr, ea);
        rd_rdy = 1'b1; tick(); rd_rdy = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            ret_valid = 1'b1; ret_data = words[b]; ret_last = (b == nbeats - 1);
            tick();
        end
        ret_valid = 1'b0; ret_last = 1'b0;
    endtask

    task automatic hit(input string t, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] exp_rd);
        int rc, wc;
        rc = rd_cnt; wc = wr_cnt;
        issue(w, a, s, d, 1'b0);
        chk({t, "_lookup_quiet"}, data_ok, 1'b0);
        tick();
        chk({t, "_data_ok_t2"}, data_ok, 1'b1);
        chk({t, "_rdata"}, rdata, exp_rd);
        tick();
        chk({t, "_pulse_end"}, data_ok, 1'b0);
        chk({t, "_no_rd"}, rd_cnt, rc);
        chk({t, "_no_wr"}, wr_cnt, wc);
    endtask

    initial begin
        int rc, wc;
        // reset state
        tick(); tick();
        chk("rst_addr_ok", addr_ok, 1'b0);
        chk("rst_data_ok", data_ok, 1'b0);
        chk("rst_rd_req", rd_req, 1'b0);
        chk("rst_wr_req", wr_req, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        tick();

        // 1: read miss then read hit
        issue(1'b0, 32'h0000_1000, 4'b0000, 32'd0, 1'b0);
        serve_rd("t1", 3'b100, 32'h0000_1000, 32'h11, 32'h22, 32'h33, 32'h44, 4);
        wait_done("t1", 32'h11);
        hit("t1_hit", 1'b0, 32'h0000_1004, 4'b0000, 32'd0, 32'h22);

        // 2: partial write hit, then read back merged word
        hit("t2_wr", 1'b1, 32'h0000_1008, 4'b0011, 32'hAAAA_BBBB, 32'd0);
        hit("t2_rd", 1'b0, 32'h0000_1008, 4'b0000, 32'd0, 32'h0000_BBBB);

        // 3: fill way 1, then conflict miss evicts dirty way 0 (rr_ptr back at 0)
        issue(1'b0, 32'h0000_2000, 4'b0000, 32'd0, 1'b0);
        serve_rd("t3a", 3'b100, 32'h0000_2000, 32'h55, 32'h66, 32'h77, 32'h88, 4);
        wait_done("t3a", 32'h55);
        issue(1'b0, 32'h0000_3000, 4'b0000, 32'd0, 1'b0);
        tick();
        chk("t3_wr_req", wr_req, 1'b1);
        chk("t3_wr_type", wr_type, 3'b100);
        chk("t3_wr_addr", wr_addr, 32'h0000_1000);
        chk("t3_wr_data", wr_data, {32'h44, 32'h0000_BBBB, 32'h22, 32'h11});
        chk("t3_no_rd_before_wb", rd_req, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_wr_req_held", wr_req, 1'b1);
        end
        wr_rdy = 1'b1; tick(); wr_rdy = 1'b0;
        chk("t3_wr_req_drop", wr_req, 1'b0);
        serve_rd("t3c", 3'b100, 32'h0000_3000, 32'h31, 32'h32, 32'h33, 32'h34, 4);
        wait_done("t3c", 32'h31);
        hit("t3_keep_way1", 1'b0, 32'h0000_2000, 4'b0000, 32'd0, 32'h55);

        // 4: uncached write to same set, cached line untouched
        rc = rd_cnt;
        issue(1'b1, 32'hBFAF_0000, 4'b1111, 32'hDEAD_BEEF, 1'b1);
        tick();
        chk("t4_wr_req", wr_req, 1'b1);
        chk("t4_wr_type", wr_type, 3'b010);
        chk("t4_wr_addr", wr_addr, 32'hBFAF_0000);
        chk("t4_wr_wstrb", wr_wstrb, 4'b1111);
        chk("t4_wr_data0", wr_data[31:0], 32'hDEAD_BEEF);
        wr_rdy = 1'b1; tick(); wr_rdy = 1'b0;
        wait_done("t4", 32'd0);
        chk("t4_no_rd", rd_cnt, rc);
        hit("t4_keep", 1'b0, 32'h0000_3000, 4'b0000, 32'd0, 32'h31);

        // 5: CACOP code 2 on dirty hit, presented together with a CPU request
        hit("t5_dirty", 1'b1, 32'h0000_3004, 4'b1111, 32'h1234_5678, 32'd0);
        rc = rd_cnt;
        valid = 1'b1; tag = 20'h00003; index = 8'h00; offset = 4'h0;
        cacop_en = 1'b1; cacop_code = 2'd2; cacop_pa = 32'h0000_3000;
        #1;
        chk("t5_addr_ok", addr_ok, 1'b1);
        tick();
        valid = 1'b0; cacop_en = 1'b0;
        tick();
        chk("t5_wr_req", wr_req, 1'b1);
        chk("t5_wr_addr", wr_addr, 32'h0000_3000);
        chk("t5_wr_data", wr_data, {32'h34, 32'h33, 32'h1234_5678, 32'h31});
        wr_rdy = 1'b1; tick(); wr_rdy = 1'b0;
        wait_done("t5_cop", 32'd0);
        chk("t5_no_lookup", rd_cnt, rc);
        wc = wr_cnt;
        cacop_en = 1'b1; cacop_code = 2'd3; cacop_pa = 32'h0000_2000;
        tick();
        cacop_en = 1'b0;
        wait_done("t5_nop", 32'd0);
        chk("t5_nop_no_wb", wr_cnt, wc);
        issue(1'b0, 32'h0000_3000, 4'b0000, 32'd0, 1'b0);
        serve_rd("t5_inv", 3'b100, 32'h0000_3000, 32'h31, 32'h32, 32'h33, 32'h34, 4);
        wait_done("t5_inv", 32'h31);

        // 6: early ret_last sets sticky err; reset during REFILL clears everything
        issue(1'b0, 32'h0000_4000, 4'b0000, 32'd0, 1'b0);
        serve_rd("t6_err", 3'b100, 32'h0000_4000, 32'h41, 32'h42, 32'h0, 32'h0, 2);
        wait_done("t6_err", 32'h41);
        chk("t6_err_set", err, 1'b1);
        hit("t6_hit", 1'b0, 32'h0000_2000, 4'b0000, 32'd0, 32'h55);
        chk("t6_err_sticky", err, 1'b1);
        issue(1'b0, 32'h0000_5000, 4'b0000, 32'd0, 1'b0);
        tick();
        chk("t6_rd_req", rd_req, 1'b1);
        rd_rdy = 1'b1; tick(); rd_rdy = 1'b0;
        ret_valid = 1'b1; ret_data = 32'h51; tick(); ret_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_rst_err", err, 1'b0);
        chk("t6_rst_rd_req", rd_req, 1'b0);
        chk("t6_rst_wr_req", wr_req, 1'b0);
        chk("t6_rst_data_ok", data_ok, 1'b0);
        tick();
        reset = 1'b0;
        ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'hFFFF_FFFF;
        tick();
        ret_valid = 1'b0; ret_last = 1'b0;
        chk("t6_stray_err", err, 1'b0);
        chk("t6_stray_data_ok", data_ok, 1'b0);
        chk("t6_idle_addr_ok", addr_ok, 1'b0);
        issue(1'b0, 32'h0000_2000, 4'b0000, 32'd0, 1'b0);
        serve_rd("t6_inv", 3'b100, 32'h0000_2000, 32'h91, 32'h92, 32'h93, 32'h94, 4);
        wait_done("t6_inv", 32'h91);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
